// File: rtl/axi_protocol_checker.sv
// Passive AXI4 memory-port checker: flags handshake stability, burst legality, last-beat,
// queue-usage and timeout violations as a registered pulse plus sticky flags. Never drives the bus.
module axi_protocol_checker #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                    axi_aclk,
    input  logic                    axi_reset,
    input  logic                    err_clear,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    input  logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    input  logic                    bready,
    output logic                    err_valid,
    output logic [3:0]              err_code,
    output logic [11:0]             err_sticky,
    output logic [4:0]              rd_outstanding,
    output logic [4:0]              wr_outstanding
);
    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam int         PTR_W      = $clog2(MAX_OUTSTANDING);
    localparam logic [2:0] MAX_SIZE   = 3'($clog2(STRB_WIDTH));
    localparam logic [4:0] Q_FULL     = 5'(MAX_OUTSTANDING);
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    // Returns {4KB crossing on INCR, size too large, reserved burst type}
    function automatic logic [2:0] burst_chk(input logic [11:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        logic [16:0] span;
        logic [16:0] end_off;
        span    = (17'(len) + 17'd1) << size;
        end_off = 17'(addr) + span;
        return {(burst == 2'b01) && (end_off > 17'd4096), size > MAX_SIZE, burst == 2'b11};
    endfunction

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;

    logic [ADDR_WIDTH+12:0]         ar_pl, aw_pl, ar_pp, aw_pp;
    logic [DATA_WIDTH+2:0]          r_pl, r_pp;
    logic [DATA_WIDTH+STRB_WIDTH:0] w_pl, w_pp;
    logic [1:0]                     b_pp;
    logic [4:0]                     pv, pr;
    assign ar_pl = {araddr, arlen, arsize, arburst};
    assign aw_pl = {awaddr, awlen, awsize, awburst};
    assign r_pl  = {rdata, rresp, rlast};
    assign w_pl  = {wdata, wstrb, wlast};

    // History is cleared on reset, which also suppresses the stall check on the first cycle after it
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            pv <= '0; pr <= '0;
            ar_pp <= '0; aw_pp <= '0; r_pp <= '0; w_pp <= '0; b_pp <= '0;
        end else begin
            pv <= {bvalid, rvalid, wvalid, awvalid, arvalid};
            pr <= {bready, rready, wready, awready, arready};
            ar_pp <= ar_pl; aw_pp <= aw_pl; r_pp <= r_pl; w_pp <= w_pl; b_pp <= bresp;
        end
    end

    logic [4:0] stall_err;
    assign stall_err[0] = pv[0] & ~pr[0] & (~arvalid | (ar_pl != ar_pp));
    assign stall_err[1] = pv[1] & ~pr[1] & (~awvalid | (aw_pl != aw_pp));
    assign stall_err[2] = pv[2] & ~pr[2] & (~wvalid  | (w_pl  != w_pp));
    assign stall_err[3] = pv[3] & ~pr[3] & (~rvalid  | (r_pl  != r_pp));
    assign stall_err[4] = pv[4] & ~pr[4] & (~bvalid  | (bresp != b_pp));

    logic [2:0] ar_chk, aw_chk;
    assign ar_chk = ar_hs ? burst_chk(araddr[11:0], arlen, arsize, arburst) : 3'b000;
    assign aw_chk = aw_hs ? burst_chk(awaddr[11:0], awlen, awsize, awburst) : 3'b000;

    logic [7:0]       rq_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rq_wp, rq_rp;
    logic [4:0]       rq_cnt;
    logic [7:0]       r_beat;
    logic             r_ok, rq_pop, rq_push, rq_over, rlast_bad, r_orphan, r_at_last;
    assign r_orphan  = r_hs & (rq_cnt == 5'd0);
    assign r_ok      = r_hs & (rq_cnt != 5'd0);
    assign r_at_last = r_beat == rq_mem[rq_rp];
    assign rq_pop    = r_ok & r_at_last;
    assign rlast_bad = r_ok & (rlast != r_at_last);
    assign rq_push   = ar_hs & ((rq_cnt != Q_FULL) | rq_pop);
    assign rq_over   = ar_hs & ~rq_push;

    logic [7:0]       wq_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wq_wp, wq_rp;
    logic [4:0]       wq_cnt, pend_b;
    logic [7:0]       w_beat;
    logic             w_ok, wq_pop, wq_push, wq_over, wlast_bad, w_orphan, w_at_last;
    logic             b_ok, b_orphan, b_inc;
    assign w_orphan  = w_hs & (wq_cnt == 5'd0);
    assign w_ok      = w_hs & (wq_cnt != 5'd0);
    assign w_at_last = w_beat == wq_mem[wq_rp];
    assign wq_pop    = w_ok & w_at_last;
    assign wlast_bad = w_ok & (wlast != w_at_last);
    assign wq_push   = aw_hs & ((wq_cnt != Q_FULL) | wq_pop);
    assign wq_over   = aw_hs & ~wq_push;
    assign b_ok      = b_hs & (pend_b != 5'd0);
    assign b_orphan  = b_hs & (pend_b == 5'd0);
    assign b_inc     = wq_pop & (pend_b != 5'd31);

    always_ff @(posedge axi_aclk) begin
        if (rq_push) rq_mem[rq_wp] <= arlen;
        if (wq_push) wq_mem[wq_wp] <= awlen;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            rq_wp <= '0; rq_rp <= '0; rq_cnt <= '0; r_beat <= '0;
            wq_wp <= '0; wq_rp <= '0; wq_cnt <= '0; w_beat <= '0; pend_b <= '0;
        end else begin
            if (rq_push) rq_wp <= rq_wp + 1'b1;
            if (rq_pop)  rq_rp <= rq_rp + 1'b1;
            if (rq_push & ~rq_pop)      rq_cnt <= rq_cnt + 5'd1;
            else if (rq_pop & ~rq_push) rq_cnt <= rq_cnt - 5'd1;
            if (rq_pop)    r_beat <= '0;
            else if (r_ok) r_beat <= r_beat + 8'd1;

            if (wq_push) wq_wp <= wq_wp + 1'b1;
            if (wq_pop)  wq_rp <= wq_rp + 1'b1;
            if (wq_push & ~wq_pop)      wq_cnt <= wq_cnt + 5'd1;
            else if (wq_pop & ~wq_push) wq_cnt <= wq_cnt - 5'd1;
            if (wq_pop)    w_beat <= '0;
            else if (w_ok) w_beat <= w_beat + 8'd1;

            if (b_inc & ~b_ok)      pend_b <= pend_b + 5'd1;
            else if (b_ok & ~b_inc) pend_b <= pend_b - 5'd1;
        end
    end

    logic [5:0] wr_sum;
    assign wr_sum         = {1'b0, wq_cnt} + {1'b0, pend_b};
    assign wr_outstanding = wr_sum[5] ? 5'd31 : wr_sum[4:0];
    assign rd_outstanding = rq_cnt;

    // Timers saturate at the limit so the timeout reports once per idle stretch
    logic [15:0] rd_tmo, wr_tmo;
    logic        rd_act, wr_act, rd_busy, wr_busy, rd_tmo_hit, wr_tmo_hit;
    assign rd_act     = ar_hs | r_hs;
    assign wr_act     = aw_hs | w_hs | b_hs;
    assign rd_busy    = rq_cnt != 5'd0;
    assign wr_busy    = wr_outstanding != 5'd0;
    assign rd_tmo_hit = rd_busy & ~rd_act & (rd_tmo == TMO_LAST);
    assign wr_tmo_hit = wr_busy & ~wr_act & (wr_tmo == TMO_LAST);

    always_ff @(posedge axi_aclk) begin
        if (axi_reset || rd_act || !rd_busy) rd_tmo <= '0;
        else if (rd_tmo != TMO_LIMIT)        rd_tmo <= rd_tmo + 16'd1;
        if (axi_reset || wr_act || !wr_busy) wr_tmo <= '0;
        else if (wr_tmo != TMO_LIMIT)        wr_tmo <= wr_tmo + 16'd1;
    end

    logic [11:0] viol;
    logic [3:0]  code_next;
    assign viol = {rd_tmo_hit | wr_tmo_hit,
                   r_orphan | w_orphan | b_orphan | rq_over | wq_over,
                   wlast_bad, rlast_bad,
                   ar_chk[2] | aw_chk[2], ar_chk[1] | aw_chk[1], ar_chk[0] | aw_chk[0],
                   stall_err[4], stall_err[3], stall_err[2], stall_err[1], stall_err[0]};

    always_comb begin
        code_next = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (viol[i]) code_next = 4'(i + 1);
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            err_valid  <= 1'b0;
            err_code   <= 4'd0;
            err_sticky <= 12'd0;
        end else begin
            err_valid  <= |viol;
            err_code   <= code_next;
            err_sticky <= (err_clear ? 12'd0 : err_sticky) | viol;
        end
    end
endmodule
